// File: rtl/fetch_mem_unit.sv
// Instruction fetch and load/store unit sharing one synchronous-read memory port; load/store wins the bus over fetch.
// Optional FMU_BUSERR_EN: load/store to addresses >= MEM_WORDS is blocked and answered with ls_err.
module fetch_mem_unit #(
   parameter int unsigned            DATA_W    = 16,
   parameter int unsigned            ADDR_W    = 12,
   parameter int unsigned            MEM_WORDS = 4096,
   parameter logic [ADDR_W-1:0]      PC_RESET  = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              exec,
   input  logic [DATA_W-1:0] m_q,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data,
   output logic              m_rw,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_done,
   output logic              ls_err,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [DATA_W-1:0] if_ir,
   output logic [ADDR_W-1:0] if_pc,
   output logic              if_valid,
   output logic              stall
);

   // RUN means a fetch was issued last cycle; DATA means a load/store was issued last cycle.
   typedef enum logic [1:0] {S_HALT = 2'd0, S_RUN = 2'd1, S_DATA = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] fpc_q;
   logic [ADDR_W-1:0] if_pc_q;
   logic [DATA_W-1:0] if_ir_q;
   logic [DATA_W-1:0] rdata_q;
   logic              we_q;
   logic              err_q;
   logic              fetch;
   logic              addr_err;
   logic [ADDR_W-1:0] issue_addr;

`ifdef FMU_BUSERR_EN
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
   assign addr_err = ls_req && ({1'b0, ls_addr} >= MEM_LIMIT);
`else
   assign addr_err = 1'b0;
`endif

   assign fetch      = exec && !ls_req;
   assign issue_addr = br_taken ? br_target : pc_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_HALT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_HALT;
      if (ls_req)    state_d = S_DATA;
      else if (exec) state_d = S_RUN;
   end

   always_comb begin
      m_addr   = pc_q;
      m_data   = '0;
      m_rw     = 1'b0;
      pc_d     = br_taken ? br_target : pc_q;
      if (ls_req) begin
         m_addr = ls_addr;
         m_data = ls_wdata;
         m_rw   = ls_we && !addr_err && !reset;
      end else if (exec) begin
         m_addr = issue_addr;
         pc_d   = issue_addr + 1'b1;
      end
      stall    = ls_req && exec;
      // A branch in the delivery cycle squashes the instruction coming back.
      if_valid = (state_q == S_RUN) && !br_taken;
      if_ir    = if_valid ? m_q   : if_ir_q;
      if_pc    = if_valid ? fpc_q : if_pc_q;
      ls_done  = (state_q == S_DATA);
      ls_err   = ls_done && err_q;
      ls_rdata = rdata_q;
      if (ls_done && !we_q) ls_rdata = err_q ? '0 : m_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= PC_RESET;
         fpc_q   <= '0;
         if_pc_q <= '0;
         if_ir_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         if (fetch) fpc_q <= issue_addr;
         if_pc_q <= if_pc;
         if_ir_q <= if_ir;
         rdata_q <= ls_rdata;
         we_q    <= ls_we;
         err_q   <= addr_err;
      end
   end

endmodule
